ising_axi_host_seq: RTL and testbench

- Hardware initiator for the ising_axi register port, replacing a software or testbench host.
- Accepts a job command and a stream of weight entries, then writes counter config, weights and START. Waits a programmed number of cycles, writes STOP, reads back all N phase registers and streams them out.
- Sits between a job source (CPU shim or on-chip ROM) and ising_axi.

---
 rtl/ising_axi_pkg.sv | 36 +++
 rtl/ising_axi_read_port.sv | 58 +++++
 rtl/ising_axi_host_seq.sv | 178 +++++++++++++++++
 tb/tb_ising_axi_host_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_axi_pkg.sv
// Shared register map and sequencer state encoding for the ising_axi host side.
// Address helpers keep the weight/phase address arithmetic in one place.
package ising_axi_pkg;

    localparam logic [31:0] START_ADDR       = 32'h0000_0000;
    localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004;
    localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008;
    localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;
    localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0010_0000;
    localparam int          WEIGHT_ROW_SHIFT = 2;
    localparam int          WEIGHT_COL_SHIFT = 13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_CUT,
        ST_CFG_MAX,
        ST_WGT,
        ST_START,
        ST_RUN,
        ST_STOP,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_EMIT,
        ST_STOP_ABORT,
        ST_DONE
    } host_state_e;

    function automatic logic [31:0] weight_addr(input logic [31:0] i, input logic [31:0] j);
        return WEIGHT_ADDR_BASE + (i << WEIGHT_ROW_SHIFT) + (j << WEIGHT_COL_SHIFT);
    endfunction

    function automatic logic [31:0] phase_addr(input logic [31:0] k);
        return PHASE_ADDR_BASE + (k << 2);
    endfunction

endpackage

// File: rtl/ising_axi_read_port.sv
// Single outstanding register read: drives the address, waits out the fixed
// read latency, captures rdata and holds it until the consumer takes it.
module ising_axi_read_port #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req,
    input  logic [31:0] req_addr,
    output logic [31:0] raddr,
    input  logic [31:0] rdata,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] data
);

    logic        waiting_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] raddr_reg;
    logic [31:0] data_reg;
    logic        valid_reg;

    // Capture one clock after the latency window closes so rdata is settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waiting_reg <= 1'b0;
            cnt_reg     <= 3'd0;
            raddr_reg   <= 32'd0;
            data_reg    <= 32'd0;
            valid_reg   <= 1'b0;
        end else if (flush) begin
            waiting_reg <= 1'b0;
            cnt_reg     <= 3'd0;
            valid_reg   <= 1'b0;
        end else if (req) begin
            raddr_reg   <= req_addr;
            waiting_reg <= 1'b1;
            cnt_reg     <= 3'd0;
            valid_reg   <= 1'b0;
        end else if (waiting_reg) begin
            if (cnt_reg == 3'(READ_LATENCY)) begin
                data_reg    <= rdata;
                valid_reg   <= 1'b1;
                waiting_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 3'd1;
            end
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign raddr = raddr_reg;
    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/ising_axi_host_seq.sv
// Hardware job sequencer for the ising_axi register port: configures counters,
// loads weights, runs for a set number of clocks, then streams back all phases.
module ising_axi_host_seq
    import ising_axi_pkg::*;
#(
    parameter int N            = 8,
    parameter int NUM_WEIGHTS  = 3,
    parameter int READ_LATENCY = 1,
    parameter int IDX_W        = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_cutoff,
    input  logic [31:0]            cmd_max,
    input  logic [31:0]            cmd_run_cycles,
    input  logic                   cmd_abort,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [IDX_W-1:0]       w_i,
    input  logic [IDX_W-1:0]       w_j,
    input  logic [NUM_WEIGHTS-1:0] w_val,
    input  logic                   w_last,
    output logic                   bus_wvalid,
    output logic [31:0]            bus_waddr,
    output logic [31:0]            bus_wdata,
    output logic [31:0]            bus_raddr,
    input  logic [31:0]            bus_rdata,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDX_W-1:0]       res_idx,
    output logic [31:0]            res_phase,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    host_state_e      state_reg;
    logic [31:0]      cutoff_reg;
    logic [31:0]      max_reg;
    logic [31:0]      run_cycles_reg;
    logic [31:0]      run_cnt_reg;
    logic [IDX_W-1:0] k_reg;
    logic             err_reg;
    logic             bus_wvalid_reg;
    logic [31:0]      bus_waddr_reg;
    logic [31:0]      bus_wdata_reg;

    logic             abort_live;
    logic             rd_req;
    logic             rd_valid;

    assign abort_live = cmd_abort && (state_reg >= ST_CFG_CUT) && (state_reg <= ST_EMIT);
    assign rd_req     = (state_reg == ST_RD_ADDR) && !cmd_abort;

    ising_axi_read_port #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_port (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort_live),
        .req      (rd_req),
        .req_addr (phase_addr(32'(k_reg))),
        .raddr    (bus_raddr),
        .rdata    (bus_rdata),
        .valid    (rd_valid),
        .ready    (res_ready),
        .data     (res_phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cutoff_reg     <= 32'd0;
            max_reg        <= 32'd0;
            run_cycles_reg <= 32'd0;
            run_cnt_reg    <= 32'd0;
            k_reg          <= '0;
            err_reg        <= 1'b0;
            bus_wvalid_reg <= 1'b0;
            bus_waddr_reg  <= 32'd0;
            bus_wdata_reg  <= 32'd0;
        end else begin
            bus_wvalid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (cmd_valid) begin
                    cutoff_reg     <= cmd_cutoff;
                    max_reg        <= cmd_max;
                    run_cycles_reg <= cmd_run_cycles;
                    err_reg        <= 1'b0;
                    state_reg      <= ST_CFG_CUT;
                end
                ST_CFG_CUT: if (cmd_abort) state_reg <= ST_DONE;
                else begin
                    bus_wvalid_reg <= 1'b1;
                    bus_waddr_reg  <= CTR_CUTOFF_ADDR;
                    bus_wdata_reg  <= cutoff_reg;
                    state_reg      <= ST_CFG_MAX;
                end
                ST_CFG_MAX: if (cmd_abort) state_reg <= ST_DONE;
                else begin
                    bus_wvalid_reg <= 1'b1;
                    bus_waddr_reg  <= CTR_MAX_ADDR;
                    bus_wdata_reg  <= max_reg;
                    state_reg      <= ST_WGT;
                end
                ST_WGT: if (cmd_abort) state_reg <= ST_DONE;
                else if (w_valid) begin
                    // Only the upper triangle is stored; anything else is dropped and flagged.
                    if (w_i < w_j) begin
                        bus_wvalid_reg <= 1'b1;
                        bus_waddr_reg  <= weight_addr(32'(w_i), 32'(w_j));
                        bus_wdata_reg  <= {{(32-NUM_WEIGHTS){1'b0}}, w_val};
                    end else begin
                        err_reg <= 1'b1;
                    end
                    if (w_last) state_reg <= ST_START;
                end
                ST_START: begin
                    bus_wvalid_reg <= 1'b1;
                    bus_waddr_reg  <= START_ADDR;
                    bus_wdata_reg  <= 32'd1;
                    run_cnt_reg    <= (run_cycles_reg == 32'd0) ? 32'd1 : run_cycles_reg;
                    state_reg      <= cmd_abort ? ST_STOP_ABORT : ST_RUN;
                end
                // START<-0 is issued on the last RUN clock so it lands exactly
                // run_cycles clocks after START<-1 on the bus.
                ST_RUN: if (cmd_abort) state_reg <= ST_STOP_ABORT;
                else begin
                    run_cnt_reg <= run_cnt_reg - 32'd1;
                    if (run_cnt_reg == 32'd1) begin
                        bus_wvalid_reg <= 1'b1;
                        bus_waddr_reg  <= START_ADDR;
                        bus_wdata_reg  <= 32'd0;
                        state_reg      <= ST_STOP;
                    end
                end
                ST_STOP: if (cmd_abort) state_reg <= ST_DONE;
                else begin
                    k_reg     <= '0;
                    state_reg <= ST_RD_ADDR;
                end
                ST_RD_ADDR: state_reg <= cmd_abort ? ST_DONE : ST_RD_WAIT;
                ST_RD_WAIT, ST_EMIT: if (cmd_abort) state_reg <= ST_DONE;
                else if (rd_valid && res_ready) begin
                    if (k_reg == IDX_W'(N-1)) state_reg <= ST_DONE;
                    else begin
                        k_reg     <= k_reg + 1'b1;
                        state_reg <= ST_RD_ADDR;
                    end
                end else if (rd_valid) begin
                    state_reg <= ST_EMIT;
                end
                ST_STOP_ABORT: begin
                    bus_wvalid_reg <= 1'b1;
                    bus_waddr_reg  <= START_ADDR;
                    bus_wdata_reg  <= 32'd0;
                    state_reg      <= ST_DONE;
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign w_ready    = (state_reg == ST_WGT) && !cmd_abort;
    assign err        = err_reg;
    assign res_valid  = rd_valid;
    assign res_idx    = k_reg;
    assign bus_wvalid = bus_wvalid_reg;
    assign bus_waddr  = bus_waddr_reg;
    assign bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_ising_axi_host_seq.sv
// Directed and randomized jobs against a register-slave model with fixed read latency.
module tb_ising_axi_host_seq;
    import ising_axi_pkg::*;

    localparam int N  = 8;
    localparam int NW = 3;
    localparam int RL = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_abort = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_cutoff = 32'd0, cmd_max = 32'd0, cmd_run_cycles = 32'd0;
    logic          w_valid = 1'b0, w_last = 1'b0, w_ready;
    logic [IW-1:0] w_i = '0, w_j = '0;
    logic [NW-1:0] w_val = '0;
    logic          bus_wvalid;
    logic [31:0]   bus_waddr, bus_wdata, bus_raddr, bus_rdata;
    logic          res_valid, res_ready = 1'b0;
    logic [IW-1:0] res_idx;
    logic [31:0]   res_phase;
    logic          busy, done, err;

    int total = 0;
    int bad = 0;

    ising_axi_host_seq #(.N(N), .NUM_WEIGHTS(NW), .READ_LATENCY(RL), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cutoff(cmd_cutoff),
        .cmd_max(cmd_max), .cmd_run_cycles(cmd_run_cycles), .cmd_abort(cmd_abort),
        .w_valid(w_valid), .w_ready(w_ready), .w_i(w_i), .w_j(w_j), .w_val(w_val), .w_last(w_last),
        .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .bus_raddr(bus_raddr), .bus_rdata(bus_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_phase(res_phase),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Register slave: phase registers readable with RL clocks of latency.
    logic [31:0] phase_mem [N];
    logic [31:0] pipe [RL];

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        int idx;
        if (a >= PHASE_ADDR_BASE && a < PHASE_ADDR_BASE + 32'(4*N)) begin
            idx = int'((a - PHASE_ADDR_BASE) >> 2);
            return phase_mem[idx];
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= slave_read(bus_raddr);
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus_rdata = pipe[RL-1];

    // Bus/event monitors.
    int          cyc = 0;
    int          done_cnt = 0;
    int          resv_cnt = 0;
    int          rd_changes = 0;
    logic [31:0] last_raddr = 32'd0;
    logic [31:0] wa_q[$], wd_q[$];
    int          wc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_wvalid) begin
            wa_q.push_back(bus_waddr);
            wd_q.push_back(bus_wdata);
            wc_q.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (res_valid) resv_cnt <= resv_cnt + 1;
        if (bus_raddr !== last_raddr) begin
            rd_changes <= rd_changes + 1;
            last_raddr <= bus_raddr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic send_weight(input int i, input int j, input int v, input bit last, output bit ok);
        w_i = IW'(i); w_j = IW'(j); w_val = NW'(v); w_last = last; w_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (w_ready) ok = 1'b1;
            clk_wait();
        end
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    int qi[$], qj[$], qv[$];

    // mode 0: full job; mode 1: abort in WGT after abort_at entries;
    // mode 2: abort abort_at clocks after the last weight.
    task automatic run_job(input string name, input logic [31:0] cut, input logic [31:0] mx,
                           input logic [31:0] rc, input int bp_k, input int mode, input int abort_at);
        logic [31:0] ea[$], ed[$];
        int  n_w, n_acc, dbefore, rbefore, vbefore, t, n, bound, results;
        bit  exp_err, ok;
        n_w = qi.size();
        n_acc = (mode == 1) ? abort_at : n_w;
        exp_err = 1'b0;
        results = 0;
        for (int k = 0; k < N; k++) phase_mem[k] = $urandom;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        dbefore = done_cnt; rbefore = rd_changes; vbefore = resv_cnt;

        ea.push_back(CTR_CUTOFF_ADDR); ed.push_back(cut);
        ea.push_back(CTR_MAX_ADDR);    ed.push_back(mx);
        for (int e = 0; e < n_acc; e++) begin
            if (qi[e] < qj[e]) begin
                ea.push_back(WEIGHT_ADDR_BASE + 32'(qi[e] * 4 + qj[e] * 8192));
                ed.push_back(32'(qv[e]));
            end else exp_err = 1'b1;
        end
        if (mode != 1) begin
            ea.push_back(START_ADDR); ed.push_back(32'd1);
            ea.push_back(START_ADDR); ed.push_back(32'd0);
        end

        cmd_cutoff = cut; cmd_max = mx; cmd_run_cycles = rc; cmd_valid = 1'b1;
        chk({name, "/cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        clk_wait();
        cmd_valid = 1'b0;
        chk({name, "/err_clear"}, 32'(err), 32'd0);
        chk({name, "/busy"}, 32'(busy), 32'd1);
        chk({name, "/cmd_ready_busy"}, 32'(cmd_ready), 32'd0);

        for (int e = 0; e < n_acc; e++) begin
            repeat ($urandom_range(0, 1)) clk_wait();
            send_weight(qi[e], qj[e], qv[e], e == n_w - 1, ok);
            chk($sformatf("%s/w_acc%0d", name, e), 32'(ok), 32'd1);
        end

        if (mode == 1) begin
            w_i = IW'(qi[abort_at]); w_j = IW'(qj[abort_at]); w_val = NW'(qv[abort_at]);
            w_valid = 1'b1; cmd_abort = 1'b1;
            #1;
            chk({name, "/w_ready_abort"}, 32'(w_ready), 32'd0);
            clk_wait();
            w_valid = 1'b0; cmd_abort = 1'b0;
        end else if (mode == 2) begin
            repeat (abort_at) clk_wait();
            chk({name, "/busy_before_abort"}, 32'(busy), 32'd1);
            cmd_abort = 1'b1;
            clk_wait();
            cmd_abort = 1'b0;
        end else begin
            bound = int'(rc) + 200;
            for (int k = 0; k < N; k++) begin
                t = 0;
                while (!res_valid && t < bound) begin clk_wait(); t++; end
                chk($sformatf("%s/res_valid%0d", name, k), 32'(res_valid), 32'd1);
                chk($sformatf("%s/res_idx%0d", name, k), 32'(res_idx), 32'(k));
                chk($sformatf("%s/res_phase%0d", name, k), res_phase, phase_mem[k]);
                if (k == bp_k) begin
                    repeat (5) begin
                        clk_wait();
                        chk($sformatf("%s/hold_valid%0d", name, k), 32'(res_valid), 32'd1);
                        chk($sformatf("%s/hold_idx%0d", name, k), 32'(res_idx), 32'(k));
                        chk($sformatf("%s/hold_phase%0d", name, k), res_phase, phase_mem[k]);
                    end
                end
                res_ready = 1'b1;
                clk_wait();
                res_ready = 1'b0;
                results++;
            end
        end

        t = 0;
        while (done_cnt == dbefore && t < 50) begin clk_wait(); t++; end
        repeat (3) clk_wait();
        chk({name, "/done_pulses"}, 32'(done_cnt - dbefore), 32'd1);
        chk({name, "/err"}, 32'(err), 32'(exp_err));
        chk({name, "/cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({name, "/busy_after"}, 32'(busy), 32'd0);
        if (mode == 0) chk({name, "/reads"}, 32'(rd_changes - rbefore), 32'(N));
        else           chk({name, "/no_results"}, 32'(resv_cnt - vbefore), 32'd0);

        chk({name, "/n_writes"}, 32'(wa_q.size()), 32'(ea.size()));
        n = (wa_q.size() < ea.size()) ? wa_q.size() : ea.size();
        for (int e = 0; e < n; e++) begin
            chk($sformatf("%s/waddr%0d", name, e), wa_q[e], ea[e]);
            chk($sformatf("%s/wdata%0d", name, e), wd_q[e], ed[e]);
        end
        if (mode == 0 && wc_q.size() == ea.size())
            chk({name, "/start_gap"}, 32'(wc_q[n-1] - wc_q[n-2]), (rc == 32'd0) ? 32'd1 : rc);
        $display("job %s: writes=%0d results=%0d err=%0b", name, wa_q.size(), results, err);
    endtask

    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst/cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/bus_wvalid", 32'(bus_wvalid), 32'd0);
        chk("rst/res_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        clk_wait();
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/raddr", bus_raddr, 32'd0);
        chk("rst/w_ready", 32'(w_ready), 32'd0);

        // Max-cut job with backpressure at k=2.
        qi = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 4};
        qj = '{1, 4, 7, 2, 3, 7, 3, 7, 4, 7, 7};
        qv = '{1, 1, 4, 1, 1, 4, 1, 4, 1, 4, 4};
        run_job("maxcut", 32'd4, 32'd8, 32'd600, 2, 0, 0);
        if (wa_q.size() > 6) chk("maxcut/w13_addr", wa_q[6], WEIGHT_ADDR_BASE + 32'h6004);

        // Illegal lower-triangle entry.
        qi = '{0, 3, 2}; qj = '{2, 1, 6}; qv = '{3, 5, 7};
        run_job("illegal", 32'd2, 32'd9, 32'd25, -1, 0, 0);

        // Randomized jobs.
        for (int r = 0; r < 2; r++) begin
            qi.delete(); qj.delete(); qv.delete();
            repeat ($urandom_range(3, 6)) begin
                qi.push_back($urandom_range(0, N-1));
                qj.push_back($urandom_range(0, N-1));
                qv.push_back($urandom_range(0, 7));
            end
            run_job($sformatf("rand%0d", r), $urandom, $urandom, 32'($urandom_range(1, 40)),
                    $urandom_range(0, N-1), 0, 0);
        end

        qi = '{0, 1, 2}; qj = '{3, 4, 5}; qv = '{1, 2, 3};
        run_job("abort_run", 32'd3, 32'd7, 32'd200, -1, 2, 10);

        qi = '{0, 1, 2, 3, 4}; qj = '{5, 6, 7, 6, 5}; qv = '{7, 6, 5, 4, 3};
        run_job("abort_wgt", 32'd1, 32'd2, 32'd50, -1, 1, 2);

        // Asynchronous reset between clock edges in the middle of WGT.
        cmd_cutoff = 32'd5; cmd_max = 32'd6; cmd_run_cycles = 32'd30; cmd_valid = 1'b1;
        clk_wait();
        cmd_valid = 1'b0;
        send_weight(4, 2, 1, 1'b0, ok);
        chk("arst/w_acc0", 32'(ok), 32'd1);
        send_weight(0, 5, 2, 1'b0, ok);
        chk("arst/w_acc1", 32'(ok), 32'd1);
        chk("arst/pre_wvalid", 32'(bus_wvalid), 32'd1);
        chk("arst/pre_err", 32'(err), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst/wvalid", 32'(bus_wvalid), 32'd0);
        chk("arst/waddr", bus_waddr, 32'd0);
        chk("arst/busy", 32'(busy), 32'd0);
        chk("arst/cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst/w_ready", 32'(w_ready), 32'd0);
        chk("arst/err", 32'(err), 32'd0);
        #2 rst = 1'b0;
        clk_wait();

        qi = '{1, 2, 6}; qj = '{7, 3, 7}; qv = '{2, 4, 6};
        run_job("after_rst_rc0", 32'd4, 32'd8, 32'd0, 5, 0, 0);

        qi = '{0, 5}; qj = '{1, 6}; qv = '{1, 1};
        run_job("rc_max", 32'd1, 32'd1, 32'hFFFF_FFFF, -1, 2, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
